// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling, one-cycle byte/error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a parity check.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | line idle, waiting for a 1->0 edge on the synced line
// ST_START   | confirming the start bit at mid-bit, glitches fall back
// ST_DATA    | sampling 8 data bits LSB first, one per bit period
// ST_PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
// ST_STOP    | sampling the stop bit and issuing the result strobe
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_parity_err_o,
    output logic       rx_busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    // Counter restarts at 0 after each sample, so the terminal value is one
    // less than the period to keep samples exactly CLKS_PER_BIT apart.
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic             r_sync1;
    logic             r_rxs;
    logic             r_rxs_d;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_busy;

    logic             w_fall;
    logic             w_tick;
    logic             w_par_bad;

    assign w_fall = r_rxs_d & ~r_rxs;
    assign w_tick = (r_clk_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    assign w_par_bad       = (^r_shift) != r_par_bit;
    assign rx_parity_err_o = r_parity_err;
`else
    assign w_par_bad       = 1'b0;
    assign rx_parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_clk_cnt == HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        if (!r_rxs) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= r_rxs;
                        r_state   <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif

                // Leave at mid-stop-bit so a start bit right behind it is caught.
                ST_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        if (!r_rxs) begin
                            r_frame_err <= 1'b1;
                        end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_clk_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o      = r_data;
    assign rx_valid_o     = r_valid;
    assign rx_frame_err_o = r_frame_err;
    assign rx_busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: frame table plus glitch and reset sequences.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_frame_err_o;
    logic       rx_parity_err_o;
    logic       rx_busy_o;

    int total;
    int bad;

    int n_valid;
    int n_ferr;
    int n_perr;
    int excl_bad;
    bit prev_any;

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_i           (rx_i),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_frame_err_o (rx_frame_err_o),
        .rx_parity_err_o(rx_parity_err_o),
        .rx_busy_o      (rx_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_valid  = 0;
        n_ferr   = 0;
        n_perr   = 0;
        excl_bad = 0;
        prev_any = 1'b0;
    end

    // Strobe monitor: counts pulses and flags overlapping or back-to-back strobes.
    always @(negedge clk) begin
        bit any;
        any = rx_valid_o | rx_frame_err_o | rx_parity_err_o;
        if (rx_valid_o)      n_valid = n_valid + 1;
        if (rx_frame_err_o)  n_ferr  = n_ferr + 1;
        if (rx_parity_err_o) n_perr  = n_perr + 1;
        if ((32'(rx_valid_o) + 32'(rx_frame_err_o) + 32'(rx_parity_err_o)) > 1)
            excl_bad = excl_bad + 1;
        if (any && prev_any)
            excl_bad = excl_bad + 1;
        prev_any = any;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_flip;
        int         gap;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int sv, sf, sp;
        total = 0;
        bad   = 0;
        rx_i  = 1'b1;
        rst   = 1'b1;

        // data, stop, par_flip, gap, exp valid/ferr/perr, exp data
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 0,  1, 0, 0, 8'hA5});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 0,  1, 0, 0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 0,  1, 0, 0, 8'hFF});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 20, 0, 1, 0, 8'hFF});
        vecs.push_back('{8'h55, 1'b1, 1'b0, 0,  1, 0, 0, 8'h55});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 0,  1, 0, 0, 8'h07});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 0,  0, 0, 1, 8'h07});
        vecs.push_back('{8'h11, 1'b0, 1'b1, 20, 0, 1, 0, 8'h07});
`endif

        repeat (5) @(posedge clk);
        #1;
        check("reset data",  32'(rx_data_o), 32'h00);
        check("reset valid", 32'(rx_valid_o), 0);
        check("reset ferr",  32'(rx_frame_err_o), 0);
        check("reset perr",  32'(rx_parity_err_o), 0);
        check("reset busy",  32'(rx_busy_o), 0);
        rst = 1'b0;
        idle(20);

        // Frames follow each other with no idle gap unless the vector asks for one.
        foreach (vecs[k]) begin
            sv = n_valid; sf = n_ferr; sp = n_perr;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].par_flip);
            check($sformatf("vec%0d valid", k), 32'(n_valid - sv), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d ferr", k),  32'(n_ferr - sf),  32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d perr", k),  32'(n_perr - sp),  32'(vecs[k].exp_perr));
            check($sformatf("vec%0d data", k),  32'(rx_data_o),    32'(vecs[k].exp_data));
            check($sformatf("vec%0d busy", k),  32'(rx_busy_o),    0);
            if (vecs[k].gap > 0) idle(vecs[k].gap);
        end
        idle(10);

        // Short low glitch on an idle line must be rejected at mid-start-bit.
        sv = n_valid; sf = n_ferr; sp = n_perr;
        rx_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("glitch busy high", 32'(rx_busy_o), 1);
        idle(15);
        check("glitch busy low", 32'(rx_busy_o), 0);
        check("glitch valid", 32'(n_valid - sv), 0);
        check("glitch ferr",  32'(n_ferr - sf), 0);
        check("glitch perr",  32'(n_perr - sp), 0);
        check("glitch data",  32'(rx_data_o), 32'h55 ^ 32'(0));

        // Reset in the middle of the data bits of 0x81.
        sv = n_valid; sf = n_ferr; sp = n_perr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_i = 1'b1;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst data",  32'(rx_data_o), 32'h00);
        check("midrst valid", 32'(rx_valid_o), 0);
        check("midrst ferr",  32'(rx_frame_err_o), 0);
        check("midrst perr",  32'(rx_parity_err_o), 0);
        check("midrst busy",  32'(rx_busy_o), 0);
        rst = 1'b0;
        idle(30);
        check("midrst no strobe", 32'(n_valid + n_ferr + n_perr - sv - sf - sp), 0);

        sv = n_valid; sf = n_ferr;
        send_frame(8'h81, 1'b1, 1'b0);
        check("post-rst valid", 32'(n_valid - sv), 1);
        check("post-rst ferr",  32'(n_ferr - sf), 0);
        check("post-rst data",  32'(rx_data_o), 32'h81);
        idle(10);
        check("post-rst hold",  32'(rx_data_o), 32'h81);

        check("strobe exclusivity", 32'(excl_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
